// File: rtl/pixel_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module  : pixel_fetch_if
//  Brief   : Display-side pixel stream and framebuffer read bus used by
//            pixel_fetch. The slave modport is the fetcher's view and the
//            master modport is the view of whoever drives it (display
//            stage plus memory).
//  Rev     : 1.0  initial release
// ============================================================================
interface pixel_fetch_if;
  // display stage side
  logic        frame_start;
  logic        pix_rd;
  logic [23:0] pix_rgb;
  logic        pix_valid;
  logic        underflow;
  // framebuffer read side
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport slave (
    input  frame_start,
    input  pix_rd,
    output pix_rgb,
    output pix_valid,
    output underflow,
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport master (
    output frame_start,
    output pix_rd,
    input  pix_rgb,
    input  pix_valid,
    input  underflow,
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/pixel_fetch.sv
`default_nettype none
// ============================================================================
//  Module  : pixel_fetch
//  Brief   : Framebuffer pixel fetcher. Reads one 32-bit word per pixel
//            from BASE_ADDR upward, keeps a small first-word-fall-through
//            FIFO topped up for the display stage and restarts on every
//            frame_start. One read request is outstanding at most.
//  Config  : define PIXEL_FETCH_UNDERFLOW_CNT_EN to add the 16-bit
//            saturating underflow_cnt output.
//  Rev     : 1.0  initial release
// ============================================================================
module pixel_fetch #(
  parameter int          HDISP      = 800,
  parameter int          VDISP      = 480,
  parameter int          FIFO_DEPTH = 16,     // power of two, >= 2
  parameter logic [31:0] BASE_ADDR  = 32'h0
) (
  input  logic         pixel_clk,
  input  logic         pixel_rst_n,
  pixel_fetch_if.slave bus
`ifdef PIXEL_FETCH_UNDERFLOW_CNT_EN
  ,
  output logic [15:0]  underflow_cnt
`endif
);

  localparam int c_TOTAL = HDISP * VDISP;
  localparam int c_NW    = (c_TOTAL > 1) ? $clog2(c_TOTAL) : 1;
  localparam int c_PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_CW    = c_PW + 1;

  localparam logic [c_NW-1:0] c_LAST = c_NW'(c_TOTAL - 1);
  localparam logic [c_CW-1:0] c_FULL = c_CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [c_NW-1:0] r_n;
  logic [c_PW-1:0] r_wr_ptr;
  logic [c_PW-1:0] r_rd_ptr;
  logic [c_CW-1:0] r_cnt;
  logic [23:0]     r_mem [0:FIFO_DEPTH-1];
  logic            r_underflow;

  logic            w_empty;
  logic            w_full;
  logic            w_pop;
  logic            w_push;
  logic            w_flush;
  logic            w_n_clr;
  logic            w_n_inc;
  logic            w_mem_req;
  logic            w_empty_rd;
  logic [31:0]     w_addr;
  logic            w_unused_rdata_hi;

  // The top byte of each framebuffer word carries no pixel data.
  assign w_unused_rdata_hi = ^bus.mem_rdata[31:24];

  assign w_empty    = (r_cnt == '0);
  assign w_full     = (r_cnt == c_FULL);
  assign w_empty_rd = bus.pix_rd & w_empty;
  // A flush wins over a pop in the same cycle.
  assign w_pop      = bus.pix_rd & ~w_empty & ~w_flush;

  // Address follows the pixel index; n only moves on ack or restart, so the
  // address is stable for the whole life of a request.
  assign w_addr = BASE_ADDR + (32'(r_n) << 2);

  // State register.
  always_ff @(posedge pixel_clk) begin
    if (!pixel_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, request and FIFO control decode.
  always_comb begin
    w_state_nxt = r_state;
    w_flush     = 1'b0;
    w_push      = 1'b0;
    w_n_clr     = 1'b0;
    w_n_inc     = 1'b0;
    w_mem_req   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.frame_start) begin
          w_flush     = 1'b1;
          w_n_clr     = 1'b1;
          w_state_nxt = REQ;
        end
      end
      REQ: begin
        // With one read in flight and pushes only on its ack, the FIFO
        // cannot fill while a request is up, so mem_req holds until ack.
        w_mem_req = ~w_full;
        if (bus.frame_start) begin
          w_flush = 1'b1;
          if (w_mem_req && !bus.mem_ack) begin
            // Outstanding read must complete before the new frame starts.
            w_state_nxt = DRAIN;
          end else begin
            w_n_clr = 1'b1;
          end
        end else if (w_mem_req && bus.mem_ack) begin
          w_push  = 1'b1;
          w_n_inc = 1'b1;
          if (r_n == c_LAST) begin
            w_state_nxt = DONE;
          end
        end
      end
      DRAIN: begin
        // Keep the stale request up; its data is thrown away.
        w_mem_req = 1'b1;
        if (bus.frame_start) begin
          w_flush = 1'b1;
        end
        if (bus.mem_ack) begin
          w_n_clr     = 1'b1;
          w_state_nxt = REQ;
        end
      end
      DONE: begin
        if (bus.frame_start) begin
          w_flush     = 1'b1;
          w_n_clr     = 1'b1;
          w_state_nxt = REQ;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Pixel index within the frame.
  always_ff @(posedge pixel_clk) begin
    if (!pixel_rst_n) begin
      r_n <= '0;
    end else if (w_n_clr) begin
      r_n <= '0;
    end else if (w_n_inc) begin
      r_n <= r_n + c_NW'(1);
    end
  end

  // FIFO pointers and occupancy; flush overrides push and pop.
  always_ff @(posedge pixel_clk) begin
    if (!pixel_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + c_CW'(1);
        2'b01:   r_cnt <= r_cnt - c_CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // FIFO storage; contents are qualified by r_cnt so no reset is needed.
  always_ff @(posedge pixel_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.mem_rdata[23:0];
    end
  end

  // Sticky underflow flag, cleared only by reset.
  always_ff @(posedge pixel_clk) begin
    if (!pixel_rst_n) begin
      r_underflow <= 1'b0;
    end else if (w_empty_rd) begin
      r_underflow <= 1'b1;
    end
  end

`ifdef PIXEL_FETCH_UNDERFLOW_CNT_EN
  logic [15:0] r_underflow_cnt;

  // Saturating count of reads attempted while the FIFO was empty.
  always_ff @(posedge pixel_clk) begin
    if (!pixel_rst_n) begin
      r_underflow_cnt <= '0;
    end else if (w_empty_rd && (r_underflow_cnt != 16'hFFFF)) begin
      r_underflow_cnt <= r_underflow_cnt + 16'd1;
    end
  end

  assign underflow_cnt = r_underflow_cnt;
`endif

  assign bus.pix_valid = ~w_empty;
  assign bus.pix_rgb   = w_empty ? 24'h0 : r_mem[r_rd_ptr];
  assign bus.underflow = r_underflow;
  assign bus.mem_req   = w_mem_req;
  assign bus.mem_addr  = w_addr;

endmodule
`default_nettype wire

// File: tb/tb_pixel_fetch.sv
`default_nettype none
// ============================================================================
//  Module  : tb_pixel_fetch
//  Brief   : Self-checking bench for pixel_fetch (4x2 frame, 4-entry FIFO,
//            base 0x1000). Memory returns rdata = address. A queue-based
//            reference model is compared every cycle; directed sequences
//            cover fill, full-frame read, restart mid-request, underflow
//            and reset mid-request.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_pixel_fetch;

  localparam int          c_DEPTH = 4;
  localparam int          c_TOTAL = 8;
  localparam logic [31:0] c_BASE  = 32'h1000;

  localparam int M_IDLE  = 0;
  localparam int M_FETCH = 1;
  localparam int M_DROP  = 2;
  localparam int M_DONE  = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  pixel_fetch_if bus ();

`ifdef PIXEL_FETCH_UNDERFLOW_CNT_EN
  logic [15:0] ucnt;
`endif

  pixel_fetch #(
    .HDISP      (4),
    .VDISP      (2),
    .FIFO_DEPTH (c_DEPTH),
    .BASE_ADDR  (c_BASE)
  ) dut (
    .pixel_clk   (clk),
    .pixel_rst_n (rst_n),
    .bus         (bus)
`ifdef PIXEL_FETCH_UNDERFLOW_CNT_EN
    ,
    .underflow_cnt (ucnt)
`endif
  );

  // Free-running pixel clock.
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [23:0] mq [$];
  int          m_mode = M_IDLE;
  int          m_n    = 0;
  bit          m_uf   = 1'b0;
  int          m_ucnt = 0;
  bit          m_sync = 1'b0;

  // memory responder state
  bit          mr_pend = 1'b0;
  int          mr_wait = 0;
  logic [31:0] mr_addr = '0;
  bit          mr_rand = 1'b0;

  logic [23:0] popped [$];

  typedef struct {
    int          ncyc;
    bit          rst;
    bit          fs;
    bit          rd;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_valid;
    logic [23:0] e_rgb;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_req();
    return ((m_mode == M_FETCH) && (mq.size() < c_DEPTH)) || (m_mode == M_DROP);
  endfunction

  task automatic model_compare();
    bit          ev;
    logic [23:0] er;
    if (!m_sync) return;
    ev = (mq.size() > 0);
    er = ev ? mq[0] : 24'h0;
    chk("model_valid", 32'(bus.pix_valid), 32'(ev));
    chk("model_rgb", 32'(bus.pix_rgb), 32'(er));
    chk("model_req", 32'(bus.mem_req), 32'(model_req()));
    if (model_req()) chk("model_addr", bus.mem_addr, c_BASE + 32'(4 * m_n));
    chk("model_underflow", 32'(bus.underflow), 32'(m_uf));
`ifdef PIXEL_FETCH_UNDERFLOW_CNT_EN
    chk("model_ucnt", 32'(ucnt), 32'(m_ucnt));
`endif
  endtask

  task automatic model_update(input bit rst, input bit fs, input bit rd,
                              input bit ack, input logic [31:0] rdata);
    bit req;
    if (!rst) begin
      mq.delete();
      m_n    = 0;
      m_mode = M_IDLE;
      m_uf   = 1'b0;
      m_ucnt = 0;
      m_sync = 1'b1;
      return;
    end
    if (!m_sync) return;
    req = model_req();
    if (rd && mq.size() == 0) begin
      m_uf = 1'b1;
      if (m_ucnt < 65535) m_ucnt++;
    end
    if (fs) begin
      mq.delete();
      if ((m_mode == M_FETCH && req && !ack) || (m_mode == M_DROP && !ack)) begin
        m_mode = M_DROP;
      end else begin
        m_mode = M_FETCH;
        m_n    = 0;
      end
    end else begin
      if (rd && mq.size() > 0) void'(mq.pop_front());
      if (m_mode == M_FETCH && req && ack) begin
        mq.push_back(rdata[23:0]);
        m_n++;
        if (m_n == c_TOTAL) m_mode = M_DONE;
      end else if (m_mode == M_DROP && ack) begin
        m_mode = M_FETCH;
        m_n    = 0;
      end
    end
  endtask

  task automatic respond();
    if (bus.mem_ack) begin
      bus.mem_ack = 1'b0;
      mr_pend     = 1'b0;
    end
    bus.mem_rdata = $urandom;
    if (mr_pend) begin
      if (mr_wait == 0) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = {8'($urandom), mr_addr[23:0]};
      end else begin
        mr_wait--;
      end
    end else if (bus.mem_req === 1'b1) begin
      mr_pend = 1'b1;
      mr_addr = bus.mem_addr;
      mr_wait = mr_rand ? $urandom_range(0, 3) : 1;
    end
  endtask

  // One clock: compare, answer memory, drive inputs, advance model.
  task automatic step(input bit rst, input bit fs, input bit rd);
    model_compare();
    respond();
    rst_n           = rst;
    bus.frame_start = fs;
    bus.pix_rd      = rd;
    if (rst && !fs && rd && bus.pix_valid === 1'b1) popped.push_back(bus.pix_rgb);
    model_update(rst, fs, rd, bus.mem_ack, bus.mem_rdata);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bit found;
    bit bad;
    bit saw_ack;
    int r;
    int rd_pct;

    bus.frame_start = 1'b0;
    bus.pix_rd      = 1'b0;
    bus.mem_ack     = 1'b0;
    bus.mem_rdata   = '0;
    @(posedge clk);
    #1;

    // ---- fill after frame_start, no reads ----
    vecs[0] = '{1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1000, 1'b0, 24'h0};
    vecs[1] = '{1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h1000, 1'b0, 24'h0};
    vecs[2] = '{3, 1'b1, 1'b0, 1'b0, 1'b1, 32'h1004, 1'b1, 24'h001000};
    vecs[3] = '{3, 1'b1, 1'b0, 1'b0, 1'b1, 32'h1008, 1'b1, 24'h001000};
    vecs[4] = '{3, 1'b1, 1'b0, 1'b0, 1'b1, 32'h100C, 1'b1, 24'h001000};
    vecs[5] = '{3, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,    1'b1, 24'h001000};
    vecs[6] = '{2, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,    1'b1, 24'h001000};
    for (int v = 0; v < 7; v++) begin
      for (int k = 0; k < vecs[v].ncyc; k++) step(vecs[v].rst, vecs[v].fs, vecs[v].rd);
      chk($sformatf("vec%0d_req", v), 32'(bus.mem_req), 32'(vecs[v].e_req));
      if (vecs[v].e_req || v == 0) chk($sformatf("vec%0d_addr", v), bus.mem_addr, vecs[v].e_addr);
      chk($sformatf("vec%0d_valid", v), 32'(bus.pix_valid), 32'(vecs[v].e_valid));
      chk($sformatf("vec%0d_rgb", v), 32'(bus.pix_rgb), 32'(vecs[v].e_rgb));
    end

    // ---- near-full: ack and pix_rd land together ----
    popped.delete();
    step(1'b1, 1'b0, 1'b1);            // pop 1000, request for 1010 rises
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);            // ack of 1010 together with pop of 1004
    chk("simul_ack_seen", 32'(bus.mem_ack), 32'd1);
    chk("simul_head", 32'(bus.pix_rgb), 32'h001008);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    chk("simul_npop", popped.size(), 32'd5);
    for (int i = 0; i < 5 && i < popped.size(); i++)
      chk($sformatf("simul_order%0d", i), 32'(popped[i]), 32'h1000 + 32'(4 * i));

    // ---- whole frame with continuous reads ----
    do_reset(6);
    step(1'b1, 1'b1, 1'b0);
    popped.delete();
    bad = 1'b0;
    for (int k = 0; k < 100 && popped.size() < c_TOTAL; k++) begin
      if (bus.mem_req === 1'b1 && bus.mem_addr == 32'h1020) bad = 1'b1;
      step(1'b1, 1'b0, 1'b1);
    end
    for (int k = 0; k < 10; k++) begin
      if (bus.mem_req === 1'b1) bad = 1'b1;
      step(1'b1, 1'b0, 1'b1);
    end
    chk("frame_npix", popped.size(), 32'(c_TOTAL));
    for (int i = 0; i < c_TOTAL && i < popped.size(); i++)
      chk($sformatf("frame_pix%0d", i), 32'(popped[i]), 32'h1000 + 32'(4 * i));
    chk("frame_no_extra_req", 32'(bad), 32'd0);
    chk("frame_done_valid", 32'(bus.pix_valid), 32'd0);

    // ---- frame_start while the 0x1008 read is outstanding ----
    do_reset(6);
    step(1'b1, 1'b1, 1'b0);
    found = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (bus.mem_req === 1'b1 && bus.mem_addr == 32'h1008) begin
        found = 1'b1;
        break;
      end
      step(1'b1, 1'b0, 1'b0);
    end
    chk("restart_found_1008", 32'(found), 32'd1);
    step(1'b1, 1'b1, 1'b0);
    chk("restart_flushed", 32'(bus.pix_valid), 32'd0);
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (bus.mem_ack === 1'b1) begin
        found = 1'b1;
        break;
      end
      chk("restart_hold_req", 32'(bus.mem_req), 32'd1);
      chk("restart_hold_addr", bus.mem_addr, 32'h1008);
      step(1'b1, 1'b0, 1'b0);
    end
    chk("restart_ack_seen", 32'(found), 32'd1);
    chk("restart_drop_valid", 32'(bus.pix_valid), 32'd0);
    chk("restart_next_req", 32'(bus.mem_req), 32'd1);
    chk("restart_next_addr", bus.mem_addr, 32'h1000);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("restart_first_pix", 32'(bus.pix_rgb), 32'h001000);

    // ---- underflow on empty reads ----
    do_reset(6);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    chk("uf_flag", 32'(bus.underflow), 32'd1);
    chk("uf_rgb", 32'(bus.pix_rgb), 32'd0);
    chk("uf_valid", 32'(bus.pix_valid), 32'd0);
`ifdef PIXEL_FETCH_UNDERFLOW_CNT_EN
    chk("uf_count", 32'(ucnt), 32'd3);
`endif
    step(1'b1, 1'b1, 1'b0);
    chk("uf_sticky", 32'(bus.underflow), 32'd1);
    do_reset(1);
    chk("uf_reset_clear", 32'(bus.underflow), 32'd0);

    // ---- reset with a read in flight; ack lands in IDLE ----
    do_reset(6);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("rst_mid_pending", 32'(mr_pend), 32'd1);
    step(1'b0, 1'b0, 1'b0);
    saw_ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b0, 1'b0);
      if (bus.mem_ack === 1'b1) saw_ack = 1'b1;
      chk("rst_mid_req", 32'(bus.mem_req), 32'd0);
      chk("rst_mid_valid", 32'(bus.pix_valid), 32'd0);
    end
    chk("rst_mid_ack_seen", 32'(saw_ack), 32'd1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("rst_mid_refetch", 32'(bus.pix_rgb), 32'h001000);

    // ---- randomized traffic against the model ----
    mr_rand = 1'b1;
    do_reset(6);
    rd_pct = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 500 == 0) rd_pct = $urandom_range(10, 90);
      r = $urandom_range(0, 999);
      if (r < 2) do_reset(6);
      else step(1'b1, ($urandom_range(0, 39) == 0), ($urandom_range(0, 99) < rd_pct));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
